i2c_slave_rx: RTL and testbench
===============================

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h77, the 7-bit address this slave answers.
REQ-002 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port scl_in  input  1  I2C clock line as seen on the bus (asynchronous).
REQ-005 SHALL have port sda_in  input  1  I2C data line as seen on the bus (asynchronous; z reads as 1).
REQ-006 SHALL have port sda_oe  output  1  1 = pull SDA low, 0 = release (open-drain; pad logic outside).
REQ-007 SHALL have port tx_data  input  8  byte returned on a master read; sampled when rd_req pulses.
REQ-008 SHALL have port rd_req  output  1  one-cycle pulse when tx_data is latched into the shifter.
REQ-009 SHALL have port rx_data  output  8  last byte received in a master write.
REQ-010 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-011 SHALL have port busy  output  1  high from address match until STOP or NACK/ignore.
REQ-012 SHALL have port nack  output  1  one-cycle pulse when the master NACKs a read byte.

Function
REQ-013 SHALL pass scl_in and sda_in through 2-flop synchronisers, plus one history flop each for edge detection (input-to-decision latency 3 clk).
REQ-014 SHALL detect START as synced SDA 1->0 while synced SCL is 1, and STOP as synced SDA 0->1 while synced SCL is 1.
REQ-015 SHALL sample data bits on a synced SCL rising edge, MSB first, and change sda_oe only on a synced SCL falling edge.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-017 SHALL go from any state to ADDR on START (repeated START included), clearing the bit counter and releasing sda_oe.
REQ-018 SHALL go from any state to IDLE on STOP, releasing sda_oe and clearing busy.
REQ-019 SHALL, in ADDR after 8 bits, go to ADDR_ACK when bits[7:1]==SLAVE_ADDR, else to IGNORE (sda_oe held 0 until START/STOP).
REQ-020 SHALL, in ADDR_ACK, assert sda_oe from the SCL falling edge after bit 8 until the following falling edge, and assert busy.
REQ-021 SHALL, after ADDR_ACK, enter WR_DATA when R/W bit = 0, or RD_DATA when R/W bit = 1, pulsing rd_req and latching tx_data at the ACK-ending falling edge.
REQ-022 SHALL, in WR_DATA after 8 bits, load rx_data, pulse rx_valid for one clk on the 8th rising edge, then ACK in WR_ACK as in REQ-020 and return to WR_DATA.
REQ-023 SHALL, in RD_DATA, drive sda_oe = ~shift[7] at each falling edge (bit 7 on the ACK-ending edge) and release sda_oe after the 8th bit's falling edge.
REQ-024 SHALL, in RD_ACK, sample SDA on the rising edge: 0 = ACK -> RD_DATA with new rd_req/tx_data latch; 1 = NACK -> pulse nack, go to IGNORE with busy cleared.
REQ-025 SHALL use a 3-bit bit counter wrapping 7->0; a 9th clock pulse is always the ACK slot.
REQ-026 SHALL give START/STOP priority over a simultaneous SCL edge in the same clk.
REQ-027 SHALL never drive SDA high; only sda_oe assert/release.

Reset
REQ-028 SHALL, while reset=1 at a clk edge, set state IDLE, sda_oe=0, rd_req=0, rx_valid=0, nack=0, busy=0, rx_data=8'h00, counters 0, synchroniser flops 1.
REQ-029 SHALL release sda_oe on the first clk edge with reset=1, even mid-ACK or mid-read-bit.
REQ-030 SHALL ignore bus activity until a fresh START after reset deasserts.

Verification
REQ-031 Write START, 0xEE (addr 0x77, W), 0xDA, STOP -> sda_oe high in both ACK slots; rx_data=0xDA with one rx_valid pulse; busy 0 after STOP.
REQ-032 START, 0xEC (addr 0x76) -> sda_oe stays 0 for whole frame; no rx_valid; busy stays 0.
REQ-033 Read START, 0xEF, tx_data=0xA5, master ACK then NACK -> SDA shows 1010_0101 twice, rd_req pulses twice, nack pulses once, sda_oe 0 after.
REQ-034 Write 0xEE, 4 data bits, repeated START, 0xEF -> no rx_valid; second address ACKed; RD_DATA entered.
REQ-035 reset=1 during WR_ACK with sda_oe=1 -> sda_oe=0 next clk; following bytes without START ignored.
REQ-036 SDA toggles while SCL held high mid-byte -> treated as START/STOP per REQ-014, not as data.

Source files
------------

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: I2C slave that acknowledges one 7-bit address and then
// either receives bytes from the master or returns bytes to it.
//
// Ports
//   clk       system clock; all state changes on its rising edge
//   reset     synchronous, active-high reset
//   scl_in    I2C clock line as seen on the bus (asynchronous)
//   sda_in    I2C data line as seen on the bus (asynchronous)
//   sda_oe    1 = pull SDA low, 0 = release (open-drain pad outside)
//   tx_data   byte returned on a master read, latched when rd_req pulses
//   rd_req    one-cycle pulse when tx_data is latched into the shifter
//   rx_data   last byte received in a master write
//   rx_valid  one-cycle pulse when rx_data updates
//   busy      high from address match until STOP, NACK or ignore
//   nack      one-cycle pulse when the master NACKs a read byte
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h77
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       rd_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       nack
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    state_t     state;
    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       rw;
    // In ack states: 0 = waiting for the edge that opens the slot,
    // 1 = slot open (slave driving, or master ACK seen on a read).
    logic       phase;

    logic scl_rise, scl_fall, start_det, stop_det;

    // Bus events from the synchronised lines; START/STOP need SCL high
    // on both samples, so they can never coincide with an SCL edge.
    assign scl_rise  =  scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 &  scl_d;
    assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
    assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;

    // Synchronisers, protocol FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_d    <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_d    <= 1'b1;
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
            rw       <= 1'b0;
            phase    <= 1'b0;
            sda_oe   <= 1'b0;
            rd_req   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            nack     <= 1'b0;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;

            rd_req   <= 1'b0;
            rx_valid <= 1'b0;
            nack     <= 1'b0;

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 3'd0;
                phase   <= 1'b0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= 3'd0;
                phase   <= 1'b0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                // shift[6:0] holds address bits, sda_s2 is R/W
                                if (shift[6:0] == SLAVE_ADDR) begin
                                    state <= ADDR_ACK;
                                    rw    <= sda_s2;
                                    busy  <= 1'b1;
                                    phase <= 1'b0;
                                end else begin
                                    state <= IGNORE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end

                    ADDR_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            if (!phase) begin
                                sda_oe <= 1'b1;
                                phase  <= 1'b1;
                            end else begin
                                phase   <= 1'b0;
                                bit_cnt <= 3'd0;
                                if (state == WR_ACK || !rw) begin
                                    state  <= WR_DATA;
                                    sda_oe <= 1'b0;
                                end else begin
                                    // Ack-ending edge also presents the MSB.
                                    state  <= RD_DATA;
                                    shift  <= tx_data;
                                    rd_req <= 1'b1;
                                    sda_oe <= ~tx_data[7];
                                end
                            end
                        end
                    end

                    WR_DATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data  <= {shift[6:0], sda_s2};
                                rx_valid <= 1'b1;
                                state    <= WR_ACK;
                                phase    <= 1'b0;
                            end
                        end
                    end

                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= RD_ACK;
                                phase <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            shift  <= {shift[6:0], 1'b0};
                            sda_oe <= ~shift[6];
                        end
                    end

                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s2) begin
                                phase <= 1'b1;
                            end else begin
                                nack   <= 1'b1;
                                state  <= IGNORE;
                                busy   <= 1'b0;
                                sda_oe <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            if (phase) begin
                                // Master ACKed: next byte starts on this edge.
                                state   <= RD_DATA;
                                phase   <= 1'b0;
                                bit_cnt <= 3'd0;
                                shift   <= tx_data;
                                rd_req  <= 1'b1;
                                sda_oe  <= ~tx_data[7];
                            end else begin
                                // Falling edge of bit 8: hand SDA to the master.
                                sda_oe <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: a bit-level I2C master with a wired-AND SDA bus,
// directed scenarios and randomized transactions checked against byte-level
// expectations (address match, byte queues, pulse counts).
module tb_i2c_slave_rx;

    localparam int unsigned Q = 8;
    localparam logic [6:0] ADDR7 = 7'h77;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m;
    logic       sda_oe;
    logic [7:0] tx_data;
    logic       rd_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       nack;
    logic       sda_bus;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int rd_cnt = 0;
    int nack_cnt = 0;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_rx #(.SLAVE_ADDR(ADDR7)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_m),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .tx_data  (tx_data),
        .rd_req   (rd_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .nack     (nack)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) rx_cnt++;
        if (rd_req) rd_cnt++;
        if (nack) nack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL pulse; returns the bus SDA level mid-high.
    task automatic send_bit(input logic b, output logic s);
        tick(2);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        s = sda_bus;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        tick(2);
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        tick(2);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ack_m, input logic [7:0] next_tx);
        logic s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, s);
            b = {b[6:0], s};
        end
        tx_data = next_tx;
        send_bit(~ack_m, s);
    endtask

    initial begin
        logic       a, s;
        logic [7:0] b;
        int         rx0, rd0, nk0;
        logic [7:0] tq[$];

        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tx_data = 8'h00;
        tick(4);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_nack", nack, 0);
        check("rst_rx_data", rx_data, 8'h00);
        reset = 1'b0;
        tick(4);

        // Write 0xDA to 0x77.
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hEE, a);
        check("wr_addr_ack", a, 1);
        write_byte(8'hDA, a);
        check("wr_data_ack", a, 1);
        check("wr_rx_data", rx_data, 8'hDA);
        check("wr_rx_count", rx_cnt - rx0, 1);
        check("wr_busy", busy, 1);
        i2c_stop();
        tick(6);
        check("wr_busy_stop", busy, 0);

        // Foreign address 0x76: never acknowledged.
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hEC, a);
        check("foreign_addr_ack", a, 0);
        check("foreign_busy", busy, 0);
        write_byte(8'h5A, a);
        check("foreign_data_ack", a, 0);
        check("foreign_rx_count", rx_cnt - rx0, 0);
        check("foreign_busy2", busy, 0);
        i2c_stop();

        // Read 0xA5 twice, ACK then NACK.
        rd0 = rd_cnt;
        nk0 = nack_cnt;
        tx_data = 8'hA5;
        i2c_start();
        write_byte(8'hEF, a);
        check("rd_addr_ack", a, 1);
        read_byte(b, 1'b1, 8'hA5);
        check("rd_byte0", b, 8'hA5);
        read_byte(b, 1'b0, 8'h00);
        check("rd_byte1", b, 8'hA5);
        tick(6);
        check("rd_req_count", rd_cnt - rd0, 2);
        check("rd_nack_count", nack_cnt - nk0, 1);
        check("rd_sda_oe_after", sda_oe, 0);
        check("rd_busy_after", busy, 0);
        i2c_stop();

        // Partial write byte cut by repeated START, then read.
        rx0 = rx_cnt;
        rd0 = rd_cnt;
        i2c_start();
        write_byte(8'hEE, a);
        check("rs_addr_ack", a, 1);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1), s);
        tx_data = 8'h3C;
        i2c_start();
        write_byte(8'hEF, a);
        check("rs_addr2_ack", a, 1);
        read_byte(b, 1'b0, 8'h00);
        check("rs_rd_byte", b, 8'h3C);
        check("rs_rx_count", rx_cnt - rx0, 0);
        check("rs_rd_count", rd_cnt - rd0, 1);
        i2c_stop();

        // Reset while the slave is driving a write ACK.
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hEE, a);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h81 >> i), s);
        tick(2);
        sda_m = 1'b1;
        tick(Q);
        check("ack_before_reset", sda_oe, 1);
        reset = 1'b1;
        tick(1);
        check("ack_reset_release", sda_oe, 0);
        reset = 1'b0;
        tick(Q);
        rx0 = rx_cnt;
        write_byte(8'hEE, a);
        check("post_reset_ack", a, 0);
        write_byte(8'h55, a);
        check("post_reset_ack2", a, 0);
        check("post_reset_rx", rx_cnt - rx0, 0);
        check("post_reset_busy", busy, 0);
        i2c_stop();

        // STOP and START in the middle of a data byte.
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hEE, a);
        send_bit(1'b1, s);
        send_bit(1'b0, s);
        send_bit(1'b1, s);
        i2c_stop();
        tick(6);
        check("mid_stop_busy", busy, 0);
        check("mid_stop_rx", rx_cnt - rx0, 0);
        i2c_start();
        write_byte(8'hEE, a);
        send_bit(1'b0, s);
        send_bit(1'b1, s);
        i2c_start();
        write_byte(8'hEE, a);
        check("mid_start_ack", a, 1);
        write_byte(8'h96, a);
        check("mid_start_rx_data", rx_data, 8'h96);
        check("mid_start_rx", rx_cnt - rx0, 1);
        i2c_stop();

        // Randomized transactions.
        for (int t = 0; t < 12; t++) begin
            logic [6:0] ad;
            logic       rwb, match;
            int         n;
            ad    = ($urandom_range(0, 1) == 1) ? ADDR7 : 7'($urandom);
            rwb   = 1'($urandom);
            n     = $urandom_range(1, 4);
            match = (ad == ADDR7);
            rx0 = rx_cnt;
            rd0 = rd_cnt;
            nk0 = nack_cnt;
            tq.delete();
            for (int k = 0; k <= n; k++) tq.push_back(8'($urandom));
            tx_data = tq[0];
            i2c_start();
            write_byte({ad, rwb}, a);
            check("rnd_addr_ack", a, 32'(match));
            check("rnd_busy", busy, 32'(match));
            if (!match) begin
                write_byte(tq[1], a);
                check("rnd_ignored_ack", a, 0);
                check("rnd_ignored_rx", rx_cnt - rx0, 0);
                check("rnd_ignored_rd", rd_cnt - rd0, 0);
            end else if (!rwb) begin
                for (int k = 0; k < n; k++) begin
                    write_byte(tq[k], a);
                    check("rnd_wr_ack", a, 1);
                    check("rnd_rx_data", rx_data, 32'(tq[k]));
                end
                check("rnd_rx_count", rx_cnt - rx0, n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    read_byte(b, k < n - 1, tq[k + 1]);
                    check("rnd_rd_byte", b, 32'(tq[k]));
                end
                tick(6);
                check("rnd_rd_count", rd_cnt - rd0, n);
                check("rnd_nack_count", nack_cnt - nk0, 1);
                check("rnd_rd_sda_oe", sda_oe, 0);
            end
            i2c_stop();
            tick(6);
            check("rnd_busy_end", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
